// File: rtl/zap_predecode_ldm_stm_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : zap_predecode_ldm_stm_fsm_if
//  Brief    : Instruction bus between the decoder and the LDM/STM predecoder.
//  Revision : 1.0
// ============================================================================
interface zap_predecode_ldm_stm_fsm_if;
    logic [34:0] i_instruction;
    logic        i_instruction_valid;
    logic        i_irq;
    logic        i_fiq;
    logic [34:0] o_instruction;
    logic        o_instruction_valid;
    logic        o_stall_from_decode;
    logic        o_irq;
    logic        o_fiq;

    // Predecoder side
    modport slave (
        input  i_instruction, i_instruction_valid, i_irq, i_fiq,
        output o_instruction, o_instruction_valid, o_stall_from_decode, o_irq, o_fiq
    );

    // Upstream/downstream environment side
    modport master (
        output i_instruction, i_instruction_valid, i_irq, i_fiq,
        input  o_instruction, o_instruction_valid, o_stall_from_decode, o_irq, o_fiq
    );
endinterface
`default_nettype wire

// File: rtl/zap_predecode_ldm_stm_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : zap_predecode_ldm_stm_fsm
//  Brief    : Expands LDM/STM into LDR/STR immediate micro-ops plus optional
//             base writeback; all other instructions pass through.
//  Revision : 1.0
// ============================================================================
module zap_predecode_ldm_stm_fsm (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_clear_from_writeback,
    input  logic                              i_data_stall,
    input  logic                              i_clear_from_alu,
    input  logic                              i_stall_from_mult,
    input  logic                              i_stall_from_shifter,
    input  logic                              i_stall_from_issue,
    zap_predecode_ldm_stm_fsm_if.slave        if_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_rem;
    logic [4:0]  r_k;

    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] f_lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Instruction fields (upstream holds the instruction while we stall)
    logic [34:0] w_in;
    logic [3:0]  w_cond;
    logic        w_p, w_u, w_s, w_w, w_l;
    logic [3:0]  w_rn;
    logic [15:0] w_list;
    logic        w_start;
    logic        w_wb_en;

    assign w_in    = if_bus.i_instruction;
    assign w_cond  = w_in[31:28];
    assign w_p     = w_in[24];
    assign w_u     = w_in[23];
    assign w_s     = w_in[22];
    assign w_w     = w_in[21];
    assign w_l     = w_in[20];
    assign w_rn    = w_in[19:16];
    assign w_list  = w_in[15:0];
    assign w_start = if_bus.i_instruction_valid && (w_in[27:25] == 3'b100) && (w_list != 16'd0);
    // A loaded base value overrides the writeback
    assign w_wb_en = w_w && !(w_l && w_list[w_rn]);

    logic [15:0] w_mask;
    logic [15:0] w_rem_next;
    logic        w_mask_last;
    logic [4:0]  w_k;
    logic [4:0]  w_n;
    logic [3:0]  w_rd;

    assign w_mask      = (r_state == S_XFER) ? r_rem : w_list;
    assign w_rem_next  = w_mask & (w_mask - 16'd1);
    assign w_mask_last = (w_rem_next == 16'd0);
    assign w_k         = (r_state == S_XFER) ? r_k : 5'd0;
    assign w_n         = f_popcount(w_list);
    assign w_rd        = f_lowest(w_mask);

    // Two's-complement offset arithmetic, sign in bit 8 (range -64..+64)
    logic [8:0]  w_4k;
    logic [8:0]  w_4n;
    logic [8:0]  w_off;
    logic [8:0]  w_abs;
    logic        w_uk;

    assign w_4k = {2'b00, w_k, 2'b00};
    assign w_4n = {2'b00, w_n, 2'b00};

    always_comb begin
        w_off = w_4k;
        case ({w_p, w_u})
            2'b01:   w_off = w_4k;
            2'b11:   w_off = w_4k + 9'd4;
            2'b00:   w_off = w_4k - w_4n + 9'd4;
            default: w_off = w_4k - w_4n;
        endcase
    end

    assign w_uk  = ~w_off[8];
    assign w_abs = w_off[8] ? (9'd0 - w_off) : w_off;

    logic [34:0] w_uop;
    logic [34:0] w_wbop;

    assign w_uop  = {w_in[34:33], w_s, w_cond, 3'b010, 1'b1, w_uk, 1'b0, 1'b0, w_l,
                     w_rn, w_rd, {3'b000, w_abs}};
    // ADD (opcode 0100) when ascending, SUB (opcode 0010) when descending
    assign w_wbop = {w_in[34:33], 1'b0, w_cond, 4'b0010, w_u, ~w_u, 2'b00,
                     w_rn, w_rn, 4'h0, w_4n[7:0]};

    logic w_final;
    assign w_final = w_mask_last && !w_wb_en;

    always_comb begin
        if_bus.o_instruction       = w_in;
        if_bus.o_instruction_valid = if_bus.i_instruction_valid;
        if_bus.o_irq               = if_bus.i_irq;
        if_bus.o_fiq               = if_bus.i_fiq;
        if_bus.o_stall_from_decode = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if_bus.o_instruction       = w_uop;
                    if_bus.o_stall_from_decode = ~w_final;
                end
            end
            S_XFER: begin
                if_bus.o_instruction       = w_uop;
                if_bus.o_instruction_valid = 1'b1;
                if_bus.o_irq               = 1'b0;
                if_bus.o_fiq               = 1'b0;
                if_bus.o_stall_from_decode = ~w_final;
            end
            S_WB: begin
                if_bus.o_instruction       = w_wbop;
                if_bus.o_instruction_valid = 1'b1;
                if_bus.o_irq               = 1'b0;
                if_bus.o_fiq               = 1'b0;
            end
            default: begin
                if_bus.o_instruction = w_in;
            end
        endcase
    end

    logic w_hold;
    assign w_hold = i_stall_from_mult || i_stall_from_shifter || i_stall_from_issue;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_rem   <= 16'd0;
            r_k     <= 5'd0;
        end else if (i_clear_from_writeback) begin
            r_state <= S_IDLE;
        end else if (i_data_stall) begin
            r_state <= r_state;
        end else if (i_clear_from_alu) begin
            r_state <= S_IDLE;
        end else if (w_hold) begin
            r_state <= r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rem <= w_rem_next;
                        r_k   <= 5'd1;
                        if (!w_mask_last) begin
                            r_state <= S_XFER;
                        end else if (w_wb_en) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_XFER: begin
                    r_rem <= w_rem_next;
                    r_k   <= r_k + 5'd1;
                    if (w_mask_last) begin
                        r_state <= w_wb_en ? S_WB : S_IDLE;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zap_predecode_ldm_stm_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zap_predecode_ldm_stm_fsm
//  Brief    : Self-checking bench for the LDM/STM predecoder.
//  Revision : 1.0
// ============================================================================
module tb_zap_predecode_ldm_stm_fsm;

    typedef logic [34:0] op_q_t [$];

    logic clk;
    logic rst;
    logic clr_wb, dstall, clr_alu, st_mult, st_shift, st_issue;
    int   total;
    int   bad;

    zap_predecode_ldm_stm_fsm_if bus ();

    zap_predecode_ldm_stm_fsm dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_clear_from_writeback (clr_wb),
        .i_data_stall           (dstall),
        .i_clear_from_alu       (clr_alu),
        .i_stall_from_mult      (st_mult),
        .i_stall_from_shifter   (st_shift),
        .i_stall_from_issue     (st_issue),
        .if_bus                 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full list of ops an instruction must produce: one transfer per listed
    // register at start+4j, then the base update if it is not overwritten.
    function automatic op_q_t expand(input logic [34:0] ins, input logic v);
        op_q_t       q;
        int          n, start, off, j, mag;
        logic [31:0] w;
        logic [3:0]  rn;
        q = {};
        if (!v || ins[27:25] != 3'b100 || ins[15:0] == 16'd0) return q;
        n  = $countones(ins[15:0]);
        rn = ins[19:16];
        case ({ins[24], ins[23]})
            2'b01:   start = 0;
            2'b11:   start = 4;
            2'b00:   start = 4 - 4 * n;
            default: start = -4 * n;
        endcase
        j = 0;
        for (int r = 0; r < 16; r++) begin
            if (ins[r]) begin
                off = start + 4 * j;
                j++;
                mag = (off < 0) ? -off : off;
                w = (32'(ins[31:28]) << 28) | 32'h0500_0000
                  | ((off >= 0) ? 32'h0080_0000 : 32'h0)
                  | (ins[20] ? 32'h0010_0000 : 32'h0)
                  | (32'(rn) << 16) | (32'(r) << 12) | 32'(mag);
                q.push_back({ins[34:33], ins[22], w});
            end
        end
        if (ins[21] && !(ins[20] && ins[rn])) begin
            w = (32'(ins[31:28]) << 28) | (ins[23] ? 32'h0280_0000 : 32'h0240_0000)
              | (32'(rn) << 16) | (32'(rn) << 12) | 32'(4 * n);
            q.push_back({ins[34:33], 1'b0, w});
        end
        return q;
    endfunction

    // Model state: ops still to be shown for the sequence in flight
    op_q_t mq;

    always @(posedge clk) begin
        if (rst || clr_wb) begin
            mq.delete();
        end else if (dstall) begin
        end else if (clr_alu) begin
            mq.delete();
        end else if (st_mult || st_shift || st_issue) begin
        end else begin
            if (mq.size() == 0) mq = expand(bus.i_instruction, bus.i_instruction_valid);
            if (mq.size() != 0) void'(mq.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [34:0] ei;
        logic        ev, es, eirq, efiq;
        op_q_t       e;
        if (!rst) begin
            if (mq.size() != 0) begin
                ei = mq[0]; ev = 1'b1; es = (mq.size() > 1); eirq = 1'b0; efiq = 1'b0;
            end else begin
                e  = expand(bus.i_instruction, bus.i_instruction_valid);
                ei = (e.size() != 0) ? e[0] : bus.i_instruction;
                es = (e.size() > 1);
                ev = bus.i_instruction_valid; eirq = bus.i_irq; efiq = bus.i_fiq;
            end
            total++;
            if (bus.o_instruction !== ei || bus.o_instruction_valid !== ev ||
                bus.o_stall_from_decode !== es || bus.o_irq !== eirq || bus.o_fiq !== efiq) begin
                bad++;
                $display("FAIL cycle_check t=%0t got ins=%h v=%b st=%b irq=%b fiq=%b want ins=%h v=%b st=%b irq=%b fiq=%b",
                         $time, bus.o_instruction, bus.o_instruction_valid, bus.o_stall_from_decode,
                         bus.o_irq, bus.o_fiq, ei, ev, es, eirq, efiq);
            end
        end
    end

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic pin(input string name, input logic [34:0] ins, input int idx,
                       input int size_want, input logic [34:0] want);
        op_q_t q;
        q = expand(ins, 1'b1);
        chk({name, "_size"}, 35'(q.size()), 35'(size_want));
        if (idx < q.size()) chk(name, q[idx], want);
        else chk(name, 35'h0, want);
    endtask

    // hk: 1 data, 2 mult, 3 shifter, 4 issue; ck: 1 alu clear, 2 writeback clear
    task automatic send(input logic [34:0] ins, input logic v, input logic irq, input logic fiq,
                        input int hk, input int ha, input int hl, input int ck, input int ca);
        int cyc;
        bit done, hold;
        cyc  = 0;
        done = 0;
        bus.i_instruction = ins; bus.i_instruction_valid = v;
        bus.i_irq = irq; bus.i_fiq = fiq;
        while (!done) begin
            hold     = (hk != 0) && cyc >= ha && cyc < ha + hl;
            dstall   = hold && hk == 1;
            st_mult  = hold && hk == 2;
            st_shift = hold && hk == 3;
            st_issue = hold && hk == 4;
            clr_alu  = (ck == 1) && cyc == ca;
            clr_wb   = (ck == 2) && cyc == ca;
            @(negedge clk);
            if (clr_wb || (clr_alu && !dstall)) done = 1;
            else if (!hold && !bus.o_stall_from_decode) done = 1;
            @(posedge clk);
            #1;
            {dstall, st_mult, st_shift, st_issue, clr_alu, clr_wb} = '0;
            cyc++;
            if (!done && cyc >= 40) begin
                total++; bad++;
                $display("FAIL seq_timeout ins=%h cycles=%0d limit=40", ins, cyc);
                done = 1;
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        {dstall, st_mult, st_shift, st_issue, clr_alu, clr_wb} = '0;
        bus.i_instruction = 35'h0_E1A00000; bus.i_instruction_valid = 1'b1;
        bus.i_irq = 1'b0; bus.i_fiq = 1'b0;

        pin("t1_op0", 35'h0_E8B00006, 0, 3, 35'h0_E5901000);
        pin("t1_op1", 35'h0_E8B00006, 1, 3, 35'h0_E5902004);
        pin("t1_wb",  35'h0_E8B00006, 2, 3, 35'h0_E2800008);
        pin("t2_op0", 35'h0_E92D4010, 0, 3, 35'h0_E50D4008);
        pin("t2_op1", 35'h0_E92D4010, 1, 3, 35'h0_E50DE004);
        pin("t2_wb",  35'h0_E92D4010, 2, 3, 35'h0_E24DD008);
        pin("t3_op0", 35'h0_E8900001, 0, 1, 35'h0_E5900000);
        pin("t3_sup", 35'h0_E8B00001, 0, 1, 35'h0_E5900000);
        pin("t4_op0", 35'h0_E8BD8000, 0, 2, 35'h0_E59DF000);
        pin("t4_wb",  35'h0_E8BD8000, 1, 2, 35'h0_E28DD004);
        pin("t5_op1", 35'h0_E99F0006, 1, 2, 35'h0_E59F2008);
        pin("t6_op0", 35'h0_E8FFFFFF, 0, 16, 35'h1_E59F0000);
        pin("t6_op15", 35'h0_E8FFFFFF, 15, 16, 35'h1_E59FF03C);
        pin("da_op0", 35'h0_E8100006, 0, 2, 35'h0_E5101004);
        pin("da_op1", 35'h0_E8100006, 1, 2, 35'h0_E5902000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out", bus.o_instruction, 35'h0_E1A00000);
        chk("reset_stall", {34'd0, bus.o_stall_from_decode}, 35'd0);
        chk("reset_valid", {34'd0, bus.o_instruction_valid}, 35'd1);
        @(posedge clk); #1;

        send(35'h0_E8B00006, 1, 0, 0, 0, 0, 0, 0, 0);
        send(35'h0_E92D4010, 1, 1, 0, 2, 1, 2, 0, 0);
        send(35'h0_E8900001, 1, 1, 1, 0, 0, 0, 0, 0);
        send(35'h0_E8B00001, 1, 0, 1, 0, 0, 0, 0, 0);
        send(35'h0_E8BD8000, 1, 0, 0, 4, 0, 3, 0, 0);
        send(35'h0_E99F0006, 1, 0, 0, 0, 0, 0, 1, 1);
        send(35'h0_E1A00000, 1, 0, 0, 0, 0, 0, 0, 0);
        send(35'h4_E8FFFFFF, 1, 0, 1, 3, 5, 2, 0, 0);
        send(35'h0_E8B00006, 1, 0, 0, 1, 1, 1, 2, 1);
        send(35'h0_E8B00006, 1, 0, 0, 1, 1, 2, 1, 1);
        send(35'h0_E8100006, 1, 1, 1, 0, 0, 0, 0, 0);
        send(35'h0_E8B00000, 1, 0, 0, 0, 0, 0, 0, 0);
        send(35'h0_E8B00006, 0, 1, 0, 0, 0, 0, 0, 0);
        send(35'h6_E1A00000, 1, 0, 1, 0, 0, 0, 0, 0);

        // Reset in the middle of a sequence must return to pass-through
        bus.i_instruction = 35'h0_E92D4010; bus.i_instruction_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_instruction = 35'h0_E1A00000;
        @(negedge clk);
        chk("midseq_reset_out", bus.o_instruction, 35'h0_E1A00000);
        chk("midseq_reset_stall", {34'd0, bus.o_stall_from_decode}, 35'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
